// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one dual-port RAM between two requesters. RAM port 0 carries at
// most one write per cycle and RAM port 1 carries at most one read per
// cycle; each port has its own round-robin pointer. Read data is captured
// from the RAM's combinational read port at the accept edge and returned
// as a one-cycle response pulse on the following cycle.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   reqN_valid/we/addr/wdata    request from requester N (held until ready)
//   reqN_ready                  combinational accept for requester N
//   rspN_valid/rdata            registered read response to requester N
//   ram_addr_0/we_0/oe_0/data_0 RAM write port drive
//   ram_addr_1/we_1/oe_1        RAM read port drive, ram_data_1 read data
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
);

  // Pointer value 1 means requester 1 was granted last, so requester 0 wins
  // the next contention.
  logic                  wr_last_q, wr_last_d;
  logic                  rd_last_q, rd_last_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic wr_cand0_s, wr_cand1_s, rd_cand0_s, rd_cand1_s;
  logic wr_gnt0_s, wr_gnt1_s, rd_gnt0_s, rd_gnt1_s;

  // Candidate detection and round-robin grant for both RAM ports.
  // Candidates are qualified with rst_n so nothing is accepted in reset.
  always_comb begin
    wr_cand0_s = rst_n & req0_valid & req0_we;
    wr_cand1_s = rst_n & req1_valid & req1_we;
    rd_cand0_s = rst_n & req0_valid & ~req0_we;
    rd_cand1_s = rst_n & req1_valid & ~req1_we;
    wr_gnt0_s  = wr_cand0_s & (~wr_cand1_s | wr_last_q);
    wr_gnt1_s  = wr_cand1_s & (~wr_cand0_s | ~wr_last_q);
    rd_gnt0_s  = rd_cand0_s & (~rd_cand1_s | rd_last_q);
    rd_gnt1_s  = rd_cand1_s & (~rd_cand0_s | ~rd_last_q);
    req0_ready = wr_gnt0_s | rd_gnt0_s;
    req1_ready = wr_gnt1_s | rd_gnt1_s;
  end

  // RAM write-port drive; zeroed when no write is granted.
  always_comb begin
    if (wr_gnt0_s) begin
      ram_we_0   = 1'b1;
      ram_oe_0   = 1'b1;
      ram_addr_0 = req0_addr;
      ram_data_0 = req0_wdata;
    end else if (wr_gnt1_s) begin
      ram_we_0   = 1'b1;
      ram_oe_0   = 1'b1;
      ram_addr_0 = req1_addr;
      ram_data_0 = req1_wdata;
    end else begin
      ram_we_0   = 1'b0;
      ram_oe_0   = 1'b0;
      ram_addr_0 = {ADDR_WIDTH{1'b0}};
      ram_data_0 = {DATA_WIDTH{1'b0}};
    end
  end

  // RAM read-port drive; port 1 never writes.
  always_comb begin
    ram_we_1 = 1'b0;
    if (rd_gnt0_s) begin
      ram_oe_1   = 1'b1;
      ram_addr_1 = req0_addr;
    end else if (rd_gnt1_s) begin
      ram_oe_1   = 1'b1;
      ram_addr_1 = req1_addr;
    end else begin
      ram_oe_1   = 1'b0;
      ram_addr_1 = {ADDR_WIDTH{1'b0}};
    end
  end

  // Next-state: pointers move only on a grant, responses pulse for one
  // cycle and the data word holds until the next read to that requester.
  always_comb begin
    if (wr_gnt0_s) begin
      wr_last_d = 1'b0;
    end else if (wr_gnt1_s) begin
      wr_last_d = 1'b1;
    end else begin
      wr_last_d = wr_last_q;
    end
    if (rd_gnt0_s) begin
      rd_last_d = 1'b0;
    end else if (rd_gnt1_s) begin
      rd_last_d = 1'b1;
    end else begin
      rd_last_d = rd_last_q;
    end
    rsp0_valid_d = rd_gnt0_s;
    rsp1_valid_d = rd_gnt1_s;
    if (rd_gnt0_s) begin
      rsp0_rdata_d = ram_data_1;
    end else begin
      rsp0_rdata_d = rsp0_rdata_q;
    end
    if (rd_gnt1_s) begin
      rsp1_rdata_d = ram_data_1;
    end else begin
      rsp1_rdata_d = rsp1_rdata_q;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_last_q    <= 1'b1;
      rd_last_q    <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp1_rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_last_q    <= wr_last_d;
      rd_last_q    <= rd_last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Single-clock arbiter that shares one `asyn_dual_port_ram` instance between two requesters. It grants at most one write per cycle, through RAM port 0, and at most one read per cycle, through RAM port 1, using independent round-robin pointers. Read data is returned one cycle after the handshake. It sits between two client engines and the RAM in single-clock builds of the FIFO subsystem.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width

Ports (N ∈ {0,1}, one set per requester):
- clk  input  1  clock; also drives RAM clk_0
- rst_n  input  1  synchronous, active-low reset
- reqN_valid  input  1  request N present
- reqN_we  input  1  1 = write, 0 = read
- reqN_addr  input  ADDR_WIDTH  target address
- reqN_wdata  input  DATA_WIDTH  write data (ignored for reads)
- reqN_ready  output  1  request N accepted this cycle (combinational)
- rspN_valid  output  1  read data for requester N valid (registered)
- rspN_rdata  output  DATA_WIDTH  read data (registered)
- ram_addr_0  output  ADDR_WIDTH  RAM write address
- ram_we_0  output  1  RAM write enable
- ram_oe_0  output  1  RAM write-in enable
- ram_data_0  output  DATA_WIDTH  RAM write data
- ram_addr_1  output  ADDR_WIDTH  RAM read address
- ram_we_1  output  1  tied 0
- ram_oe_1  output  1  RAM read enable
- ram_data_1  input  DATA_WIDTH  RAM read data (combinational)

## Operation
- Handshake: a transfer occurs when reqN_valid && reqN_ready at a rising edge. reqN_ready depends on reqN_valid and reqN_we in the same cycle, but never on reqN_ready of the other requester. Requesters hold all fields until accepted.
- Write arbiter:
  - Candidates: reqN_valid && reqN_we.
  - With one candidate, grant it.
  - With two candidates, grant the requester that is not wr_last. wr_last updates to the granted index on every write grant.
- Read arbiter: identical scheme over reqN_valid && !reqN_we, with its own pointer rd_last.
- A write grant and a read grant may occur in the same cycle to different requesters. One requester is granted at most once per cycle, since it presents only one request.
- RAM drive on a write grant:
  - ram_we_0 = ram_oe_0 = 1.
  - ram_addr_0 and ram_data_0 are taken from the granted requester.
  - Otherwise ram_we_0 = ram_oe_0 = 0 and ram_addr_0 / ram_data_0 = 0.
- RAM drive on a read grant: ram_oe_1 = 1 and ram_addr_1 = the granted address. Otherwise ram_oe_1 = 0 and ram_addr_1 = 0. ram_we_1 is always 0.
- Read response:
  - At the edge that accepts a read from N, rspN_rdata <= ram_data_1 and rspN_valid <= 1.
  - rspN_valid is a one-cycle pulse.
  - rspN_rdata holds its value until the next read response to N.
  - There is no response backpressure.
- Read and write to the same address in the same cycle: the read returns the old contents, and the new value is visible from the next cycle.
- No response is generated for writes.

## Timing
- Reset (rst_n = 0 sampled at a rising edge):
  - wr_last = rd_last = 1, so requester 0 wins the first contention.
  - rsp0_valid = rsp1_valid = 0 and rsp0_rdata = rsp1_rdata = 0.
  - While rst_n = 0: reqN_ready = 0, ram_we_0 = ram_oe_0 = ram_oe_1 = 0, and all RAM address/data outputs = 0. No RAM write occurs.
- Reset mid-operation: any read accepted before the reset edge still registers its response at that edge? No. Reset has priority, so rspN_valid = 0 after the reset edge and the in-flight response is dropped.
- Write latency: committed at the accept edge and readable by a read accepted in the following cycle.
- Read latency: rspN_valid is asserted the cycle after acceptance. With a continuous stream, back-to-back reads give one response per cycle.
- Fairness: under continuous contention, grants alternate 0,1,0,1,… per port. The maximum wait is 1 cycle.
- Pointers update only on a grant. Idle cycles preserve them.

## Test plan
- Reset then single write: req0 writes addr 3, data 0xA5 -> req0_ready = 1 in the same cycle, and ram_we_0 = ram_oe_0 = 1 with ram_addr_0 = 3. A read by req1 of addr 3 in the next cycle -> rsp1_valid one cycle later with rsp1_rdata = 0xA5.
- Write contention: both requesters hold writes (req0: addr 1 / 0x11, req1: addr 2 / 0x22) for 4 cycles -> grants in order 0,1,0,1. req0 is granted first after reset.
- Concurrent read/write: req0 writes addr 5 = 0x5A while req1 reads addr 5, which holds 0x00, in the same cycle -> both ready = 1 and rsp1_rdata = 0x00. A re-read in the next cycle returns 0x5A.
- Read contention: both requesters read addrs 0 and 15 continuously for 4 cycles -> alternating grants and one rspN_valid pulse per grant, each with the correct data. Address 15 exercises the address wrap boundary.
- Reset mid-stream: rst_n low for 1 cycle while req0 reads -> rsp0_valid = 0 after the reset edge, no RAM enables during reset, and the pointers return to favor requester 0.
- Idle pointer hold: a req1 write is granted, then 3 idle cycles, then both write -> req0 is granted first.
